// File: rtl/cu_microseq_if.sv
// cu_microseq_if: sequencer control/status bundle between the control word register and the sequencer
// slave modport: sequencer side, master modport: control word / test driver side
interface cu_microseq_if #(
  parameter int ADDR_W      = 7,
  parameter int OPC_W       = 4,
  parameter int STACK_DEPTH = 4
);
  logic [2:0]                         i_seq_op;
  logic [ADDR_W-1:0]                  i_branch_addr;
  logic [1:0]                         i_cond_sel;
  logic                               i_cond_inv;
  logic [OPC_W-1:0]                   i_opcode;
  logic                               i_indirect;
  logic                               i_zf;
  logic                               i_nf;
  logic                               i_mf;
  logic                               i_halt;
  logic                               i_step_en;
  logic                               i_next_instr;
  logic                               i_map_we;
  logic [OPC_W-1:0]                   i_map_addr;
  logic [ADDR_W-1:0]                  i_map_data;
  logic [ADDR_W-1:0]                  o_car_addr;
  logic [$clog2(STACK_DEPTH+1)-1:0]   o_stack_depth;
  logic                               o_halted;
  logic                               o_wait_step;
  logic [1:0]                         o_err;
  modport slave (
    input  i_seq_op, i_branch_addr, i_cond_sel, i_cond_inv, i_opcode, i_indirect,
           i_zf, i_nf, i_mf, i_halt, i_step_en, i_next_instr, i_map_we, i_map_addr, i_map_data,
    output o_car_addr, o_stack_depth, o_halted, o_wait_step, o_err
  );
  modport master (
    output i_seq_op, i_branch_addr, i_cond_sel, i_cond_inv, i_opcode, i_indirect,
           i_zf, i_nf, i_mf, i_halt, i_step_en, i_next_instr, i_map_we, i_map_addr, i_map_data,
    input  o_car_addr, o_stack_depth, o_halted, o_wait_step, o_err
  );
endinterface

// File: rtl/cu_microseq.sv
// cu_microseq: microprogram sequencer driving the control-address register (CAR)
// Optional call/return stack enabled by defining CU_MSEQ_CALL_STACK_EN.
// Ports: i_clk (rising edge), i_rst (async, active-high), io_bus (cu_microseq_if.slave):
//   seq op, branch target/condition, IR opcode/indirect bit, ALU flags, halt/step controls,
//   dispatch-map write port; outputs CAR, stack depth, halted, wait-step, sticky errors.
module cu_microseq #(
  parameter int ADDR_W        = 7,
  parameter int OPC_W         = 4,
  parameter int STACK_DEPTH   = 4,
  parameter int FETCH_ADDR    = 0,
  parameter int INDIRECT_ADDR = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  cu_microseq_if.slave   io_bus
);
  localparam logic [ADDR_W-1:0] FETCH = ADDR_W'(FETCH_ADDR);
  localparam logic [ADDR_W-1:0] IND   = ADDR_W'(INDIRECT_ADDR);
  logic [ADDR_W-1:0] r_car;
  logic              r_ind_done;
  logic [ADDR_W-1:0] r_map [2**OPC_W];
  logic [ADDR_W-1:0] w_inc;
  logic [ADDR_W-1:0] w_next;
  logic              w_flag;
  logic              w_cond;
  logic              w_eoi_hold;
  logic              w_eoi;
  assign w_inc      = r_car + ADDR_W'(1);
  assign w_flag     = io_bus.i_cond_sel == 2'b00 ? 1'b1 :
                      io_bus.i_cond_sel == 2'b01 ? io_bus.i_zf :
                      io_bus.i_cond_sel == 2'b10 ? io_bus.i_nf : io_bus.i_mf;
  assign w_cond     = w_flag ^ io_bus.i_cond_inv;
  assign w_eoi      = io_bus.i_seq_op == 3'b011;
  assign w_eoi_hold = io_bus.i_halt | (io_bus.i_step_en & ~io_bus.i_next_instr);
  assign io_bus.o_halted    = w_eoi & io_bus.i_halt;
  assign io_bus.o_wait_step = w_eoi & ~io_bus.i_halt & io_bus.i_step_en & ~io_bus.i_next_instr;
  assign io_bus.o_car_addr  = r_car;
`ifdef CU_MSEQ_CALL_STACK_EN
  localparam int DW = $clog2(STACK_DEPTH+1);
  localparam int SW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
  logic [DW-1:0]     r_depth;
  logic [1:0]        r_err;
  logic              w_full;
  logic              w_empty;
  logic [SW-1:0]     w_push_idx;
  logic [SW-1:0]     w_top_idx;
  assign w_full     = r_depth == DW'(STACK_DEPTH);
  assign w_empty    = r_depth == '0;
  assign w_push_idx = SW'(r_depth);
  assign w_top_idx  = SW'(r_depth - DW'(1));
  assign io_bus.o_stack_depth = r_depth;
  assign io_bus.o_err         = r_err;
`else
  assign io_bus.o_stack_depth = '0;
  assign io_bus.o_err         = '0;
`endif
  always_comb begin
    w_next = r_car;
    case (io_bus.i_seq_op)
      3'b001:  w_next = w_inc;
      3'b010:  w_next = (io_bus.i_indirect && !r_ind_done) ? IND : r_map[io_bus.i_opcode];
      3'b011:  w_next = w_eoi_hold ? r_car : FETCH;
      3'b100:  w_next = w_cond ? io_bus.i_branch_addr : w_inc;
`ifdef CU_MSEQ_CALL_STACK_EN
      3'b101:  w_next = w_full ? r_car : io_bus.i_branch_addr;
      3'b110:  w_next = w_empty ? FETCH : r_stack[w_top_idx];
`endif
      default: w_next = r_car;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_car      <= FETCH;
      r_ind_done <= 1'b0;
      for (int k = 0; k < 2**OPC_W; k++) r_map[k] <= FETCH;
    end else begin
      r_car <= w_next;
      if (io_bus.i_map_we) r_map[io_bus.i_map_addr] <= io_bus.i_map_data;
      if (io_bus.i_seq_op == 3'b010 && io_bus.i_indirect && !r_ind_done) r_ind_done <= 1'b1;
      else if (w_eoi && !w_eoi_hold) r_ind_done <= 1'b0;
    end
  end
`ifdef CU_MSEQ_CALL_STACK_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_depth <= '0;
      r_err   <= '0;
    end else begin
      case (io_bus.i_seq_op)
        3'b011:  if (!w_eoi_hold) r_depth <= '0;
        3'b101:  if (w_full) r_err[0] <= 1'b1; else r_depth <= r_depth + DW'(1);
        3'b110:  if (w_empty) r_err[1] <= 1'b1; else r_depth <= r_depth - DW'(1);
        default: r_depth <= r_depth;
      endcase
    end
  end
  // Entries above r_depth are dead, so the storage itself needs no reset.
  always_ff @(posedge i_clk) begin
    if (io_bus.i_seq_op == 3'b101 && !w_full) r_stack[w_push_idx] <= w_inc;
  end
`endif
endmodule

// File: tb/tb_cu_microseq.sv
// tb_cu_microseq: scoreboard bench for cu_microseq (covers both stack-enabled and stack-less builds)
module tb_cu_microseq;
`ifdef CU_MSEQ_CALL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif
  typedef struct {
    string      nm;
    logic [6:0] car;
    logic [2:0] d;
    logic       h;
    logic       w;
    logic [1:0] e;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic [2:0] e_d = '0;
  logic [1:0] e_err = '0;
  cu_microseq_if #(.ADDR_W(7), .OPC_W(4), .STACK_DEPTH(4)) bus ();
  cu_microseq #(.ADDR_W(7), .OPC_W(4), .STACK_DEPTH(4), .FETCH_ADDR(0), .INDIRECT_ADDR(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic clr();
    bus.i_seq_op = 3'b000; bus.i_branch_addr = '0; bus.i_cond_sel = 2'b00; bus.i_cond_inv = 1'b0;
    bus.i_opcode = '0; bus.i_indirect = 1'b0; bus.i_zf = 1'b0; bus.i_nf = 1'b0; bus.i_mf = 1'b0;
    bus.i_halt = 1'b0; bus.i_step_en = 1'b0; bus.i_next_instr = 1'b0;
    bus.i_map_we = 1'b0; bus.i_map_addr = '0; bus.i_map_data = '0;
  endtask
  task automatic step(input string nm, input logic [6:0] car, input logic h = 1'b0, input logic w = 1'b0);
    exp_t it;
    it.nm = nm; it.car = car; it.d = e_d; it.h = h; it.w = w; it.e = e_err;
    q.push_back(it);
    @(posedge clk);
    @(negedge clk);
    clr();
  endtask
  task automatic br(input logic [6:0] a);
    bus.i_seq_op = 3'b100; bus.i_branch_addr = a;
    step("br_always", a);
  endtask
  // Monitor: comb outputs sampled at the edge, registered outputs 1 time unit later.
  initial begin
    logic h, w;
    exp_t it;
    forever begin
      @(posedge clk);
      h = bus.o_halted;
      w = bus.o_wait_step;
      #1;
      if (q.size() > 0) begin
        it = q.pop_front();
        chk({it.nm, ".car"}, {1'b0, bus.o_car_addr}, {1'b0, it.car});
        chk({it.nm, ".depth"}, {5'b0, bus.o_stack_depth}, {5'b0, it.d});
        chk({it.nm, ".err"}, {6'b0, bus.o_err}, {6'b0, it.e});
        chk({it.nm, ".halted"}, {7'b0, h}, {7'b0, it.h});
        chk({it.nm, ".wait"}, {7'b0, w}, {7'b0, it.w});
      end
    end
  end
  initial begin
    clr();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step("reset", 7'h00);
    bus.i_map_we = 1'b1; bus.i_map_addr = 4'd3; bus.i_map_data = 7'h0B; bus.i_seq_op = 3'b010; bus.i_opcode = 4'd3;
    step("map_same_cycle", 7'h00);
    bus.i_seq_op = 3'b010; bus.i_opcode = 4'd3;
    step("dispatch", 7'h0B);
    bus.i_map_we = 1'b1; bus.i_map_addr = 4'd5; bus.i_map_data = 7'h30;
    step("hold", 7'h0B);
    bus.i_seq_op = 3'b011;
    step("eoi", 7'h00);
    bus.i_seq_op = 3'b010; bus.i_opcode = 4'd5; bus.i_indirect = 1'b1;
    step("ind_first", 7'h02);
    bus.i_seq_op = 3'b010; bus.i_opcode = 4'd5; bus.i_indirect = 1'b1;
    step("ind_second", 7'h30);
    bus.i_seq_op = 3'b011;
    step("eoi2", 7'h00);
    bus.i_seq_op = 3'b010; bus.i_opcode = 4'd5; bus.i_indirect = 1'b1;
    step("ind_again", 7'h02);
    bus.i_seq_op = 3'b011;
    step("eoi3", 7'h00);
    br(7'h10);
    bus.i_seq_op = 3'b100; bus.i_cond_sel = 2'b01; bus.i_cond_inv = 1'b1; bus.i_branch_addr = 7'h40;
    step("br_nzf_taken", 7'h40);
    br(7'h10);
    bus.i_seq_op = 3'b100; bus.i_cond_sel = 2'b01; bus.i_cond_inv = 1'b1; bus.i_zf = 1'b1; bus.i_branch_addr = 7'h40;
    step("br_nzf_not", 7'h11);
    bus.i_seq_op = 3'b100; bus.i_cond_sel = 2'b10; bus.i_nf = 1'b1; bus.i_branch_addr = 7'h20;
    step("br_nf", 7'h20);
    bus.i_seq_op = 3'b100; bus.i_cond_sel = 2'b11; bus.i_branch_addr = 7'h60;
    step("br_mf_not", 7'h21);
    bus.i_seq_op = 3'b100; bus.i_cond_inv = 1'b1; bus.i_branch_addr = 7'h60;
    step("br_never", 7'h22);
    br(7'h7F);
    bus.i_seq_op = 3'b001;
    step("inc_wrap", 7'h00);
    br(7'h05);
    bus.i_seq_op = 3'b101; bus.i_branch_addr = 7'h50;
    if (STK) e_d = 3'd1;
    step("call_one", STK ? 7'h50 : 7'h05);
    bus.i_seq_op = 3'b011;
    e_d = 3'd0;
    step("eoi_clears", 7'h00);
    br(7'h05);
    for (int i = 1; i <= 5; i++) begin
      bus.i_seq_op = 3'b101; bus.i_branch_addr = 7'h05;
      if (STK) begin
        if (i <= 4) e_d = 3'(i);
        else e_err = 2'b01;
      end
      step("call", 7'h05);
    end
    for (int i = 1; i <= 5; i++) begin
      bus.i_seq_op = 3'b110;
      if (STK && i <= 4) e_d = 3'(4 - i);
      if (STK && i == 5) e_err = 2'b11;
      step("ret", !STK ? 7'h05 : (i <= 4 ? 7'h06 : 7'h00));
    end
    br(7'h33);
    bus.i_seq_op = 3'b001; bus.i_step_en = 1'b1; bus.i_next_instr = 1'b1;
    step("pulse_ignored", 7'h34);
    bus.i_seq_op = 3'b011; bus.i_step_en = 1'b1;
    step("wait_step1", 7'h34, 1'b0, 1'b1);
    bus.i_seq_op = 3'b011; bus.i_step_en = 1'b1;
    step("wait_step2", 7'h34, 1'b0, 1'b1);
    bus.i_seq_op = 3'b011; bus.i_step_en = 1'b1; bus.i_next_instr = 1'b1;
    step("step_go", 7'h00);
    br(7'h22);
    bus.i_seq_op = 3'b011; bus.i_halt = 1'b1; bus.i_step_en = 1'b1; bus.i_next_instr = 1'b1;
    step("halt_pulse", 7'h22, 1'b1, 1'b0);
    bus.i_seq_op = 3'b011; bus.i_halt = 1'b1;
    step("halt_hold", 7'h22, 1'b1, 1'b0);
    bus.i_seq_op = 3'b011;
    step("halt_release", 7'h00);
    br(7'h15);
    bus.i_seq_op = 3'b111;
    step("reserved_hold", 7'h15);
    br(7'h12);
    bus.i_seq_op = 3'b101; bus.i_branch_addr = 7'h44;
    if (STK) e_d = 3'd1;
    step("call_pre_rst", STK ? 7'h44 : 7'h12);
    #2 rst = 1'b1;
    #1;
    chk("async_rst.car", {1'b0, bus.o_car_addr}, 8'h00);
    chk("async_rst.depth", {5'b0, bus.o_stack_depth}, 8'h00);
    chk("async_rst.err", {6'b0, bus.o_err}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    e_d = 3'd0; e_err = 2'b00;
    br(7'h10);
    bus.i_seq_op = 3'b010; bus.i_opcode = 4'd3;
    step("map_after_rst", 7'h00);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
